// File: rtl/trace_plotter_pkg.sv
// Shared definitions for the trace plotter and the scan-out reader: default
// geometry, FSM state encoding and framebuffer address packing.
package trace_plotter_pkg;

    localparam int XW_DEF = 8;
    localparam int YW_DEF = 8;
    localparam int CW_DEF = 12;

    typedef enum logic {
        IDLE = 1'b0,
        SPAN = 1'b1
    } state_t;

    // Framebuffer word address: row in the upper bits, column in the lower bits.
    function automatic logic [YW_DEF+XW_DEF-1:0] fb_pack(
        input logic [YW_DEF-1:0] row,
        input logic [XW_DEF-1:0] col
    );
        return {row, col};
    endfunction

endpackage

// File: rtl/trace_plotter.sv
// Turns per-column waveform samples into framebuffer pixel writes, filling the
// vertical gap to the previous column so the trace draws as a continuous line.
module trace_plotter
    import trace_plotter_pkg::*;
#(
    parameter int XW     = XW_DEF,
    parameter int YW     = YW_DEF,
    parameter int CW     = CW_DEF,
    parameter int Y_FLIP = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XW-1:0]    in_x,
    input  logic [YW-1:0]    in_y,
    input  logic [CW-1:0]    in_color,
    input  logic             in_connect,
    output logic             fb_we,
    output logic [YW+XW-1:0] fb_addr,
    output logic [CW-1:0]    fb_data,
    output logic             busy
);

    // Handshake: a sample transfers on a rising clk edge where in_valid && in_ready;
    // in_ready is high exactly while the FSM is IDLE and does not depend on in_valid.

    state_t        state, state_n;
    logic          prev_valid;
    logic [XW-1:0] prev_x;
    logic [YW-1:0] prev_y;
    logic [YW-1:0] span_row;
    logic [YW-1:0] span_hi;
    logic [XW-1:0] span_col;
    logic [CW-1:0] span_color;

    logic [YW-1:0] y_in;
    logic          accept;
    logic          adjacent;
    logic          connect;
    logic [YW-1:0] lo;
    logic [YW-1:0] hi;

    assign y_in     = (Y_FLIP != 0) ? ~in_y : in_y;
    assign in_ready = (state == IDLE);
    assign accept   = in_valid && (state == IDLE);

    // Compare one bit wider so column 2^XW-1 followed by column 0 is not adjacent.
    assign adjacent = ({1'b0, in_x} == ({1'b0, prev_x} + (XW+1)'(1)));
    // A frame_start on the accept edge already means "no previous point".
    assign connect  = in_connect && prev_valid && !frame_start && adjacent;
    assign lo       = (prev_y < y_in) ? prev_y : y_in;
    assign hi       = (prev_y < y_in) ? y_in : prev_y;

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept && connect && (lo != hi)) state_n = SPAN;
            SPAN: if (span_row == span_hi) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            busy       <= 1'b0;
            prev_valid <= 1'b0;
            prev_x     <= '0;
            prev_y     <= '0;
            span_row   <= '0;
            span_hi    <= '0;
            span_col   <= '0;
            span_color <= '0;
        end else begin
            fb_we <= 1'b0;
            busy  <= (state_n == SPAN);
            if (frame_start) prev_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        prev_valid <= 1'b1;
                        prev_x     <= in_x;
                        prev_y     <= y_in;
                        fb_we      <= 1'b1;
                        fb_data    <= in_color;
                        span_col   <= in_x;
                        span_color <= in_color;
                        span_hi    <= hi;
                        if (connect) begin
                            // The lowest row goes out now; the rest follow one per cycle.
                            fb_addr  <= {lo, in_x};
                            span_row <= lo + YW'(1);
                        end else begin
                            fb_addr  <= {y_in, in_x};
                        end
                    end
                end
                SPAN: begin
                    fb_we   <= 1'b1;
                    fb_addr <= {span_row, span_col};
                    fb_data <= span_color;
                    // Stop at equality so a span ending on the top row never wraps.
                    if (span_row != span_hi) span_row <= span_row + YW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
